// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the BaseRAM arbiter: FSM encoding, grant ids,
// idle strobe levels and the legal range of the access wait count.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_W_SETUP = 3'd2,
    ST_W_PULSE = 3'd3,
    ST_W_HOLD  = 3'd4,
    ST_DONE    = 3'd5
  } sram_state_e;

  localparam logic GNT_VID  = 1'b0;
  localparam logic GNT_HOST = 1'b1;

  localparam logic       STROBE_OFF = 1'b1;
  localparam logic [3:0] BE_N_OFF   = 4'hF;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  function automatic bit wait_cycles_legal(input int w);
    return (w >= WAIT_MIN) && (w <= WAIT_MAX);
  endfunction

endpackage

// File: rtl/sram_access_seq.sv
// Access timing FSM for the asynchronous SRAM: strobe ordering, wait counter
// and the data-bus drive enable. Address/data come from the arbiter's latches.
module sram_access_seq
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic we_i,
  output logic busy_o,
  output logic capture_o,
  output logic done_o,
  output logic bus_drv_o,
  output logic ram_ce_n_o,
  output logic ram_oe_n_o,
  output logic ram_we_n_o
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  sram_state_e state_q, state_d;
  logic [3:0]  wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = we_i ? ST_W_SETUP : ST_RD;
      ST_RD: begin
        if (wait_q == WAIT_LAST) state_d = ST_DONE;
        else                     wait_d  = wait_q + 4'd1;
      end
      ST_W_SETUP: state_d = ST_W_PULSE;
      ST_W_PULSE: begin
        if (wait_q == WAIT_LAST) state_d = ST_W_HOLD;
        else                     wait_d  = wait_q + 4'd1;
      end
      ST_W_HOLD:  state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // oe_n and bus drive are never active in the same state, so no contention.
  always_comb begin
    ram_ce_n_o = STROBE_OFF;
    ram_oe_n_o = STROBE_OFF;
    ram_we_n_o = STROBE_OFF;
    bus_drv_o  = 1'b0;
    capture_o  = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_RD: begin
        ram_ce_n_o = 1'b0;
        ram_oe_n_o = 1'b0;
        capture_o  = (wait_q == WAIT_LAST);
      end
      ST_W_SETUP, ST_W_HOLD: begin
        ram_ce_n_o = 1'b0;
        bus_drv_o  = 1'b1;
      end
      ST_W_PULSE: begin
        ram_ce_n_o = 1'b0;
        ram_we_n_o = 1'b0;
        bus_drv_o  = 1'b1;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/sram_arbiter.sv
// Video/host arbiter for the BaseRAM: grants in IDLE, latches the request and
// routes read data. Optional host anti-starvation: SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W           = 20,
  parameter int DATA_W           = 32,
  parameter int WAIT_CYCLES      = 2,
  parameter int MAX_VIDEO_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic [3:0]        host_be_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              busy_o,
  inout  wire  [DATA_W-1:0] ram_data_io,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_be_n_o,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o
);

  if (!wait_cycles_legal(WAIT_CYCLES) || DATA_W != 32 || MAX_VIDEO_STREAK < 1) begin : g_param_err
    $error("sram_arbiter: WAIT_CYCLES must be 1..15, DATA_W 32, MAX_VIDEO_STREAK >= 1");
  end

  logic seq_busy, seq_capture, seq_done, bus_drv;
  logic gnt_vld, gnt_host, gnt_we, host_first;

  logic              gnt_q,   gnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_n_q,  be_n_d;
  logic [DATA_W-1:0] vid_rdata_q,  vid_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  assign gnt_vld  = !seq_busy && (vid_req_i || host_req_i);
  assign gnt_host = host_req_i && (!vid_req_i || host_first);
  assign gnt_we   = gnt_host && host_we_i;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_VIDEO_STREAK + 1);
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Only video grants that actually held the host off count toward the streak.
  always_comb begin
    streak_d = streak_q;
    if (gnt_vld) begin
      if (gnt_host)        streak_d = '0;
      else if (host_req_i) streak_d = streak_q + 1'b1;
      else                 streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

  assign host_first = host_req_i && (streak_q == STREAK_W'(MAX_VIDEO_STREAK));
`else
  assign host_first = 1'b0;
`endif

  always_comb begin
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_n_d  = be_n_q;
    if (gnt_vld) begin
      gnt_d   = gnt_host ? GNT_HOST : GNT_VID;
      addr_d  = gnt_host ? host_addr_i : vid_addr_i;
      wdata_d = host_wdata_i;
      be_n_d  = gnt_we ? ~host_be_i : 4'h0;
    end
  end

  always_comb begin
    vid_rdata_d  = vid_rdata_q;
    host_rdata_d = host_rdata_q;
    if (seq_capture) begin
      if (gnt_q == GNT_VID) vid_rdata_d  = ram_data_io;
      else                  host_rdata_d = ram_data_io;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q        <= GNT_VID;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_n_q       <= BE_N_OFF;
      vid_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_n_q       <= be_n_d;
      vid_rdata_q  <= vid_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  sram_access_seq #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start_i    (gnt_vld),
    .we_i       (gnt_we),
    .busy_o     (seq_busy),
    .capture_o  (seq_capture),
    .done_o     (seq_done),
    .bus_drv_o  (bus_drv),
    .ram_ce_n_o (ram_ce_n_o),
    .ram_oe_n_o (ram_oe_n_o),
    .ram_we_n_o (ram_we_n_o)
  );

  assign ram_data_io  = bus_drv ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr_o   = addr_q;
  assign ram_be_n_o   = be_n_q;
  assign vid_ack_o    = seq_done && (gnt_q == GNT_VID);
  assign host_ack_o   = seq_done && (gnt_q == GNT_HOST);
  assign vid_rdata_o  = vid_rdata_q;
  assign host_rdata_o = host_rdata_q;
  assign busy_o       = seq_busy;

endmodule
